// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Opcode encodings and FSM state type for the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Bit 0 of the instruction distinguishes register-type from branch-type.
    localparam logic OP_R = 1'b0;
    localparam logic OP_B = 1'b1;

    typedef enum logic [1:0] {
        FU_IDLE = 2'd0,
        FU_REQ  = 2'd1,
        FU_HOLD = 2'd2
    } fu_state_e;

    function automatic logic is_branch_op(input logic op_bit);
        return (op_bit == OP_B);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory and execute-side signals of the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int DW = 8,
    parameter int IW = 8,
    parameter int AW = 8,
    parameter int CW = 16
);
    logic          halt;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          imem_valid;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] alu_out;
    logic [AW-1:0] pc;
    logic [CW-1:0] retire_cnt;

    modport master (
        input  halt, imem_rdata, imem_valid, instr_ready, alu_out,
        output imem_req, imem_addr, instr, instr_valid, pc, retire_cnt
    );

    modport slave (
        output halt, imem_rdata, imem_valid, instr_ready, alu_out,
        input  imem_req, imem_addr, instr, instr_valid, pc, retire_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pc_next
//  Description : Next-PC adder; branches add the offset, others step by one.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_pc_next #(
    parameter int AW = 8
) (
    input  logic [AW-1:0] pc,
    input  logic          is_branch,
    input  logic [AW-1:0] offset,
    output logic [AW-1:0] next_pc
);
    // Modulo-2^AW wrap is intentional.
    assign next_pc = pc + (is_branch ? offset : AW'(1));
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : PC / instruction fetch stage with valid-ready output to execute.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DW       = 8,
    parameter int IW       = 8,
    parameter int AW       = 8,
    parameter int RESET_PC = 0,
    parameter int CW       = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam logic [AW-1:0] C_RESET_PC = AW'(RESET_PC);

    fu_state_e     r_state;
    fu_state_e     w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_pc_step;
    logic [IW-1:0] r_instr;
    logic [IW-1:0] w_instr_nxt;
    logic          r_instr_valid;
    logic          w_instr_valid_nxt;
    logic [CW-1:0] r_retire_cnt;
    logic [CW-1:0] w_retire_cnt_nxt;
    logic          w_imem_req;
    logic          w_is_branch;

    assign w_is_branch = is_branch_op(r_instr[0]);

    fetch_unit_pc_next #(
        .AW(AW)
    ) u_pc_next (
        .pc        (r_pc),
        .is_branch (w_is_branch),
        .offset    (bus.alu_out[AW-1:0]),
        .next_pc   (w_pc_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FU_IDLE;
            r_pc          <= C_RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_retire_cnt  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_retire_cnt  <= w_retire_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_retire_cnt_nxt  = r_retire_cnt;
        w_imem_req        = 1'b0;
        case (r_state)
            FU_IDLE: begin
                // Responses arriving here are stale and deliberately ignored.
                if (!bus.halt) begin
                    w_state_nxt = FU_REQ;
                end
            end
            FU_REQ: begin
                w_imem_req = 1'b1;
                if (bus.imem_valid) begin
                    w_instr_nxt       = bus.imem_rdata;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = FU_HOLD;
                end
            end
            FU_HOLD: begin
                // halt only gates the following fetch, never the handshake.
                if (r_instr_valid && bus.instr_ready) begin
                    w_pc_nxt          = w_pc_step;
                    w_retire_cnt_nxt  = r_retire_cnt + CW'(1);
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = bus.halt ? FU_IDLE : FU_REQ;
                end
            end
            default: begin
                w_state_nxt = FU_IDLE;
            end
        endcase
    end

    assign bus.imem_req    = w_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.pc          = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.retire_cnt  = r_retire_cnt;

endmodule
`default_nettype wire
